// File: rtl/trig_pkg.sv
// Shared constants, types and helpers for the PMT pulse conditioner.
// Optional feature macro: GLITCH_FILTER_EN (fourth sync stage, two-sample edge
// qualification, arm window widened to cover the extra stage).
package trig_pkg;

    localparam int unsigned NCHAN  = 8;
    localparam int unsigned DT_W   = 8;
    localparam int unsigned DROP_W = 16;
    localparam int unsigned SUM_W  = DROP_W + 1;
    localparam int unsigned POP_W  = $clog2(NCHAN + 1);

`ifdef GLITCH_FILTER_EN
    localparam int unsigned ARM_EDGES = 4;
`else
    localparam int unsigned ARM_EDGES = 3;
`endif
    localparam int unsigned ARM_W = $clog2(ARM_EDGES + 1);

    typedef logic [NCHAN-1:0] chan_vec_t;
    typedef logic [DT_W-1:0]  deadtime_t;
    typedef logic [POP_W-1:0] pop_t;

    typedef enum logic {
        LIVE = 1'b0,
        DEAD = 1'b1
    } chan_state_t;

    // Number of set bits in a channel vector
    function automatic pop_t popcount(input chan_vec_t v);
        pop_t n;
        n = '0;
        for (int i = 0; i < int'(NCHAN); i++) begin
            n = n + pop_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pmt_pulse_conditioner_if.sv
// Control/status bundle of the PMT pulse conditioner.
// master: the side that drives discriminator levels and settings; slave: the conditioner.
interface pmt_pulse_conditioner_if;
    import trig_pkg::*;

    chan_vec_t           pmt_in;
    chan_vec_t           chan_en;
    deadtime_t           deadtime;
    logic                clear_dropped;
    chan_vec_t           buffer;
    chan_vec_t           busy;
    logic [DROP_W-1:0]   dropped_total;

    modport master (
        output pmt_in, chan_en, deadtime, clear_dropped,
        input  buffer, busy, dropped_total
    );

    modport slave (
        input  pmt_in, chan_en, deadtime, clear_dropped,
        output buffer, busy, dropped_total
    );

endinterface

// File: rtl/pmt_chan_deadtime.sv
// One PMT channel: synchroniser, rising-edge detect and LIVE/DEAD deadtime FSM.
// Optional feature macro: GLITCH_FILTER_EN (adds stage s4; a rise must be seen
// on two consecutive samples before it counts as an edge).
module pmt_chan_deadtime
    import trig_pkg::*;
(
    input  logic      clkin,
    input  logic      reset,
    input  logic      pmt_in,
    input  logic      chan_en,
    input  deadtime_t deadtime,
    input  logic      armed,
    output logic      hit,
    output logic      busy,
    output logic      drop_c
);

    logic        s1, s2, s3;
    logic        rise_c;
    logic        hit_next;
    chan_state_t state, state_next;
    deadtime_t   cnt, cnt_next;

    // Bring the asynchronous discriminator level into the clkin domain
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pmt_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

`ifdef GLITCH_FILTER_EN
    logic s4;

    // Extra history stage so a rise must persist for two samples
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            s4 <= 1'b0;
        end else begin
            s4 <= s3;
        end
    end

    assign rise_c = s2 & s3 & ~s4;
`else
    assign rise_c = s2 & ~s3;
`endif

    // FSM state, window counter and registered hit/busy
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state <= LIVE;
            cnt   <= '0;
            hit   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            hit   <= hit_next;
            busy  <= (cnt_next != '0);
        end
    end

    // Accept edges while LIVE; count the window down and flag suppressed edges while DEAD
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hit_next   = 1'b0;
        drop_c     = 1'b0;
        if (!chan_en) begin
            state_next = LIVE;
            cnt_next   = '0;
        end else begin
            unique case (state)
                LIVE: begin
                    if (armed && rise_c) begin
                        hit_next = 1'b1;
                        if (deadtime != '0) begin
                            state_next = DEAD;
                            cnt_next   = deadtime;
                        end
                    end
                end
                DEAD: begin
                    drop_c   = armed & rise_c;
                    cnt_next = cnt - DT_W'(1);
                    if (cnt == DT_W'(1)) begin
                        state_next = LIVE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pmt_pulse_conditioner.sv
// PMT front end: per-channel sync/edge/deadtime, reset-release arm window and a
// saturating count of edges suppressed by deadtime.
// Optional feature macro: GLITCH_FILTER_EN (see trig_pkg and pmt_chan_deadtime).
module pmt_pulse_conditioner
    import trig_pkg::*;
(
    input  logic                    clkin,
    input  logic                    reset,
    pmt_pulse_conditioner_if.slave  bus
);

    logic [ARM_W-1:0]  arm_cnt;
    logic              armed;
    chan_vec_t         hit_vec;
    chan_vec_t         busy_vec;
    chan_vec_t         drop_vec;
    logic [DROP_W-1:0] dropped_total;
    logic [SUM_W-1:0]  drop_sum_c;

    // Hold hits and drop counting off for the first clkin edges after reset release
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + ARM_W'(1);
        end
    end

    assign armed = (arm_cnt == ARM_W'(ARM_EDGES));

    // One independent conditioner per PMT channel
    for (genvar c = 0; c < int'(NCHAN); c++) begin : g_chan
        pmt_chan_deadtime u_chan (
            .clkin    (clkin),
            .reset    (reset),
            .pmt_in   (bus.pmt_in[c]),
            .chan_en  (bus.chan_en[c]),
            .deadtime (bus.deadtime),
            .armed    (armed),
            .hit      (hit_vec[c]),
            .busy     (busy_vec[c]),
            .drop_c   (drop_vec[c])
        );
    end

    assign drop_sum_c = {1'b0, dropped_total} + SUM_W'(popcount(drop_vec));

    // Saturating dropped-edge total; clear wins over drops in the same cycle
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            dropped_total <= '0;
        end else if (bus.clear_dropped) begin
            dropped_total <= '0;
        end else if (drop_sum_c[DROP_W]) begin
            dropped_total <= '1;
        end else begin
            dropped_total <= drop_sum_c[DROP_W-1:0];
        end
    end

    assign bus.buffer        = hit_vec;
    assign bus.busy          = busy_vec;
    assign bus.dropped_total = dropped_total;

endmodule

// File: tb/tb_pmt_pulse_conditioner.sv
// Self-checking bench for pmt_pulse_conditioner: directed scenarios plus a random
// phase, every cycle compared against a timeline model of the channel rules.
// Honours GLITCH_FILTER_EN the same way the design does.
module tb_pmt_pulse_conditioner;
    import trig_pkg::*;

`ifdef GLITCH_FILTER_EN
    localparam int ARM  = 4;
    localparam int FILT = 1;
`else
    localparam int ARM  = 3;
    localparam int FILT = 0;
`endif

    logic clkin = 1'b0;
    logic reset = 1'b0;

    pmt_pulse_conditioner_if bus ();

    pmt_pulse_conditioner dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    int checks = 0;
    int errors = 0;

    // Reference model: input history, edge index since release, per-channel
    // index of the last edge still inside the deadtime window.
    logic [7:0] h [0:4];
    int         edge_no;
    int         win_end [8];
    logic [7:0] exp_buf;
    logic [7:0] exp_busy;
    int         exp_drop;

    // Observed statistics for scenario-level checks
    int hits [8];
    int busy_cycles [8];
    int full_words;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) h[i] = '0;
        for (int c = 0; c < 8; c++) win_end[c] = 0;
        edge_no  = 0;
        exp_buf  = '0;
        exp_busy = '0;
        exp_drop = 0;
    endtask

    task automatic clear_stats();
        for (int c = 0; c < 8; c++) begin
            hits[c]        = 0;
            busy_cycles[c] = 0;
        end
        full_words = 0;
    endtask

    function automatic int sum_hits();
        int s;
        s = 0;
        for (int c = 0; c < 8; c++) s += hits[c];
        return s;
    endfunction

    // Advance one clkin edge, predict outputs from the rules, compare
    task automatic step();
        int   drops;
        logic rise;
        @(posedge clkin);
        edge_no++;
        for (int i = 4; i > 0; i--) h[i] = h[i-1];
        h[0]     = bus.pmt_in;
        drops    = 0;
        exp_buf  = '0;
        exp_busy = '0;
        for (int c = 0; c < 8; c++) begin
`ifdef GLITCH_FILTER_EN
            rise = h[2][c] & h[3][c] & ~h[4][c];
`else
            rise = h[2][c] & ~h[3][c];
`endif
            if (!bus.chan_en[c]) begin
                win_end[c] = edge_no;
            end else if (rise && edge_no > ARM) begin
                if (edge_no <= win_end[c]) begin
                    drops++;
                end else begin
                    exp_buf[c] = 1'b1;
                    win_end[c] = edge_no + int'(bus.deadtime);
                end
            end
            exp_busy[c] = bus.chan_en[c] && (win_end[c] > edge_no);
        end
        if (bus.clear_dropped) exp_drop = 0;
        else exp_drop = (exp_drop + drops > 65535) ? 65535 : exp_drop + drops;
        #1;
        check("buffer", 32'(bus.buffer), 32'(exp_buf));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("dropped_total", 32'(bus.dropped_total), 32'(exp_drop));
        for (int c = 0; c < 8; c++) begin
            hits[c]        += int'(bus.buffer[c]);
            busy_cycles[c] += int'(bus.busy[c]);
        end
        if (bus.buffer == 8'hFF) full_words++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #2;
        check("reset_buffer", 32'(bus.buffer), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_dropped", 32'(bus.dropped_total), 32'h0);
        @(posedge clkin);
        @(posedge clkin);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] pat;
        int         per;
        int         phase;

        bus.pmt_in        = '0;
        bus.chan_en       = '1;
        bus.deadtime      = 8'd4;
        bus.clear_dropped = 1'b0;
        model_reset();
        clear_stats();
        #1;
        apply_reset();
        run(6);

        // Single edge on ch0 with deadtime 4
        clear_stats();
        bus.pmt_in = 8'h01;
        run(12);
        check("t1_hits_ch0", 32'(hits[0]), 32'd1);
        check("t1_busy_cycles_ch0", 32'(busy_cycles[0]), 32'd4);
        check("t1_total_hits", 32'(sum_hits()), 32'd1);
        bus.pmt_in = 8'h00;
        run(4);

        // ch3: one edge inside the window (dropped), one just past it (accepted)
        bus.clear_dropped = 1'b1;
        run(1);
        bus.clear_dropped = 1'b0;
        clear_stats();
        pat = (FILT != 0) ? 8'b1101_1011 : 8'b1110_1101;
        for (int i = 0; i < 8; i++) begin
            bus.pmt_in[3] = pat[i];
            run(1);
        end
        run(8);
        check("t2_hits_ch3", 32'(hits[3]), 32'd2);
        check("t2_dropped", 32'(bus.dropped_total), 32'd1);
        bus.pmt_in = 8'h00;
        run(8);

        // deadtime 0: every rise on ch5 becomes a hit
        bus.deadtime      = 8'd0;
        bus.clear_dropped = 1'b1;
        run(1);
        bus.clear_dropped = 1'b0;
        clear_stats();
        per = (FILT != 0) ? 4 : 2;
        for (int i = 0; i < 10 * per; i++) begin
            bus.pmt_in[5] = ((i % per) < per / 2);
            run(1);
        end
        bus.pmt_in = 8'h00;
        run(6);
        check("t3_hits_ch5", 32'(hits[5]), 32'd10);
        check("t3_dropped", 32'(bus.dropped_total), 32'd0);

        // All lines high through reset release, then a common fall and rise
        bus.deadtime = 8'd4;
        bus.pmt_in   = 8'hFF;
        apply_reset();
        clear_stats();
        run(10);
        check("t4_no_hits_after_release", 32'(sum_hits()), 32'd0);
        bus.pmt_in = 8'h00;
        run(4);
        bus.pmt_in = 8'hFF;
        run(8);
        check("t4_full_words", 32'(full_words), 32'd1);
        check("t4_total_hits", 32'(sum_hits()), 32'd8);
        bus.pmt_in = 8'h00;
        run(4);

        // Drive dropped_total into saturation, then clear under concurrent drops
        bus.deadtime = 8'd255;
        phase = 0;
        for (int i = 0; i < 40000 && exp_drop < 65535; i++) begin
            bus.pmt_in = ((phase % 4) < 2) ? 8'hFF : 8'h00;
            phase++;
            step();
        end
        for (int i = 0; i < 12; i++) begin
            bus.pmt_in = ((phase % 4) < 2) ? 8'hFF : 8'h00;
            phase++;
            step();
        end
        check("t5_saturated", 32'(bus.dropped_total), 32'h0000_FFFF);
        bus.clear_dropped = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.pmt_in = ((phase % 4) < 2) ? 8'hFF : 8'h00;
            phase++;
            step();
        end
        check("t5_cleared", 32'(bus.dropped_total), 32'h0);
        bus.clear_dropped = 1'b0;
        bus.pmt_in        = 8'h00;
        run(260);

        // ch1: one-cycle pulse, three-cycle pulse, then disable mid-window
        bus.deadtime      = 8'd20;
        bus.clear_dropped = 1'b1;
        run(1);
        bus.clear_dropped = 1'b0;
        clear_stats();
        bus.pmt_in = 8'h02;
        run(1);
        bus.pmt_in = 8'h00;
        run(6);
        bus.pmt_in = 8'h02;
        run(3);
        bus.pmt_in = 8'h00;
        run(6);
        check("t6_busy1_mid_window", 32'(bus.busy[1]), 32'd1);
        bus.chan_en = 8'hFD;
        run(1);
        check("t6_busy1_cleared", 32'(bus.busy[1]), 32'd0);
        bus.pmt_in[1] = 1'b1;
        run(3);
        bus.chan_en = 8'hFF;
        run(6);
        check("t6_hits_ch1", 32'(hits[1]), 32'd1);
        check("t6_dropped", 32'(bus.dropped_total), 32'((FILT != 0) ? 0 : 1));
        bus.pmt_in = 8'h00;
        run(4);

        // Random levels, enables, deadtimes and clears
        for (int i = 0; i < 1500; i++) begin
            bus.pmt_in        = bus.pmt_in ^ (8'($urandom) & 8'($urandom));
            bus.chan_en       = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'hFF;
            bus.deadtime      = 8'($urandom_range(0, 9));
            bus.clear_dropped = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
